// File: rtl/register_bist.sv
// Built-in self test for a single WIDTH-bit register with synchronous reset.
// Runs four write/read-back steps and reports pass/fail, error count and first failure.
module register_bist #(
    parameter int WIDTH        = 8,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_data_in,
    output logic             dut_rst,
    input  logic [WIDTH-1:0] dut_data_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [3:0]       err_count,
    output logic [1:0]       fail_step,
    output logic [WIDTH-1:0] fail_value
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_CHECK  = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic             drst_q, drst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [3:0]       err_q, err_d;
    logic [1:0]       fstep_q, fstep_d;
    logic [WIDTH-1:0] fval_q, fval_d;
    logic             mismatch_s;
    logic [3:0]       err_next_s;

    function automatic logic [WIDTH-1:0] step_data(input logic [1:0] step);
        case (step)
            2'd0:    step_data = {(WIDTH/2){2'b01}};
            2'd1:    step_data = {(WIDTH/2){2'b10}};
            default: step_data = {WIDTH{1'b1}};
        endcase
    endfunction

    function automatic logic step_rst(input logic [1:0] step);
        step_rst = (step == 2'd3);
    endfunction

    function automatic logic [WIDTH-1:0] step_expect(input logic [1:0] step);
        case (step)
            2'd3:    step_expect = {WIDTH{1'b0}};
            default: step_expect = step_data(step);
        endcase
    endfunction

    // Compare read-back; the if/else form sends any unknown bit down the mismatch path.
    always_comb begin
        if (dut_data_out == step_expect(step_q)) begin
            mismatch_s = 1'b0;
        end else begin
            mismatch_s = 1'b1;
        end
    end

    // Saturating error count including the current step's result.
    always_comb begin
        if (mismatch_s && (err_q != 4'd15)) begin
            err_next_s = err_q + 4'd1;
        end else begin
            err_next_s = err_q;
        end
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        din_d   = din_q;
        drst_d  = drst_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fail_d  = fail_q;
        err_d   = err_q;
        fstep_d = fstep_q;
        fval_d  = fval_q;
        case (state_q)
            S_IDLE: begin
                din_d  = {WIDTH{1'b0}};
                drst_d = 1'b0;
                if (start) begin
                    state_d = S_DRIVE;
                    step_d  = 2'd0;
                    err_d   = 4'd0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    fstep_d = 2'd0;
                    fval_d  = {WIDTH{1'b0}};
                    busy_d  = 1'b1;
                    din_d   = step_data(2'd0);
                    drst_d  = step_rst(2'd0);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRIVE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                err_d = err_next_s;
                if (mismatch_s && (err_q == 4'd0)) begin
                    fstep_d = step_q;
                    fval_d  = dut_data_out;
                end else begin
                    fstep_d = fstep_q;
                end
                if ((step_q != 2'd3) && !((STOP_ON_FAIL == 1'b1) && mismatch_s)) begin
                    state_d = S_DRIVE;
                    step_d  = step_q + 2'd1;
                    din_d   = step_data(step_q + 2'd1);
                    drst_d  = step_rst(step_q + 2'd1);
                end else begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                    pass_d  = (err_next_s == 4'd0);
                    fail_d  = (err_next_s != 4'd0);
                    busy_d  = 1'b0;
                    din_d   = {WIDTH{1'b0}};
                    drst_d  = 1'b0;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            din_q   <= {WIDTH{1'b0}};
            drst_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= 4'd0;
            fstep_q <= 2'd0;
            fval_q  <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            din_q   <= din_d;
            drst_q  <= drst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            fstep_q <= fstep_d;
            fval_q  <= fval_d;
        end
    end

    assign dut_data_in = din_q;
    assign dut_rst     = drst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign err_count   = err_q;
    assign fail_step   = fstep_q;
    assign fail_value  = fval_q;

endmodule

// File: tb/tb_register_bist.sv
// Scoreboard bench for register_bist: two instances (run-all and stop-on-fail)
// each driving a fault-injectable register model.
module tb_register_bist;

    typedef struct packed {
        logic [63:0] din_seq;
        logic [7:0]  rst_seq;
        logic [4:0]  cyc;
        logic        pass;
        logic        fail;
        logic [3:0]  err;
        logic [1:0]  fstep;
        logic [7:0]  fval;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din   [2];
    logic       drst  [2];
    logic [7:0] dout  [2];
    logic       busy  [2];
    logic       done  [2];
    logic       pass  [2];
    logic       fail  [2];
    logic [3:0] errc  [2];
    logic [1:0] fstep [2];
    logic [7:0] fval  [2];

    logic [7:0] and_m;
    logic [7:0] or_m;
    logic       ign_rst;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;

    register_bist #(.WIDTH(8), .STOP_ON_FAIL(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .dut_data_in(din[0]), .dut_rst(drst[0]), .dut_data_out(dout[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail(fail[0]),
        .err_count(errc[0]), .fail_step(fstep[0]), .fail_value(fval[0])
    );

    register_bist #(.WIDTH(8), .STOP_ON_FAIL(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .dut_data_in(din[1]), .dut_rst(drst[1]), .dut_data_out(dout[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail(fail[1]),
        .err_count(errc[1]), .fail_step(fstep[1]), .fail_value(fval[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int sb_size(input int g);
        return (g == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t sb_pop(input int g);
        if (g == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Reference model: what the BIST should conclude about a register with the given faults.
    function automatic exp_t model(input bit stop, input logic [7:0] am, input logic [7:0] om, input bit ign);
        exp_t e;
        logic [7:0] stim, want, got;
        bit r;
        int last;
        e = '0;
        last = 3;
        for (int s = 0; s < 4; s++) begin
            stim = (s == 0) ? 8'h55 : (s == 1) ? 8'hAA : 8'hFF;
            r    = (s == 3);
            want = r ? 8'h00 : stim;
            got  = (((r && !ign) ? 8'h00 : stim) & am) | om;
            e.din_seq[16*s +: 16] = {stim, stim};
            e.rst_seq[2*s +: 2]   = {r, r};
            if (got != want) begin
                if (e.err == 4'd0) begin
                    e.fstep = 2'(s);
                    e.fval  = got;
                end
                e.err = e.err + 4'd1;
                if (stop) begin
                    last = s;
                    break;
                end
            end
        end
        e.cyc  = 5'(2 * last + 3);
        e.pass = (e.err == 4'd0);
        e.fail = (e.err != 4'd0);
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_rut
        logic [7:0] reg_q;
        always @(posedge clk) begin
            if (drst[g] && !ign_rst) reg_q <= 8'h00;
            else reg_q <= din[g];
        end
        assign dout[g] = (reg_q & and_m) | or_m;

        // Monitor: records the stimulus of a run and checks results at each done pulse.
        initial begin : mon
            int cyc;
            bit act;
            logic [63:0] sd;
            logic [7:0] sr;
            exp_t e;
            act = 1'b0; cyc = 0; sd = '0; sr = '0;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    act = 1'b0;
                end else begin
                    if (busy[g] && !act) begin
                        act = 1'b1; cyc = 0; sd = '0; sr = '0;
                    end
                    if (act) cyc++;
                    if (act && busy[g] && cyc >= 1 && cyc <= 8) begin
                        sd[(cyc-1)*8 +: 8] = din[g];
                        sr[cyc-1] = drst[g];
                    end
                    if (done[g]) begin
                        if (sb_size(g) == 0) begin
                            chk($sformatf("unexpected_done%0d", g), 64'(done[g]), 64'd0);
                        end else begin
                            e = sb_pop(g);
                            chk($sformatf("done_cycle%0d", g), 64'(cyc), 64'(e.cyc));
                            chk($sformatf("stim_data%0d", g), sd, e.din_seq);
                            chk($sformatf("stim_rst%0d", g), 64'(sr), 64'(e.rst_seq));
                            chk($sformatf("pass%0d", g), 64'(pass[g]), 64'(e.pass));
                            chk($sformatf("fail%0d", g), 64'(fail[g]), 64'(e.fail));
                            chk($sformatf("err_count%0d", g), 64'(errc[g]), 64'(e.err));
                            chk($sformatf("fail_step%0d", g), 64'(fstep[g]), 64'(e.fstep));
                            chk($sformatf("fail_value%0d", g), 64'(fval[g]), 64'(e.fval));
                            chk($sformatf("finish_outs%0d", g), 64'({busy[g], drst[g], din[g]}), 64'd0);
                        end
                        act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s%0d", tag, g),
                64'({busy[g], done[g], pass[g], fail[g], errc[g], fstep[g], fval[g], din[g], drst[g]}),
                64'd0);
        end
    endtask

    task automatic set_fault(input logic [7:0] am, input logic [7:0] om, input logic ign);
        and_m = am; or_m = om; ign_rst = ign;
    endtask

    task automatic run(input bit extra_starts);
        bit seen;
        q0.push_back(model(1'b0, and_m, or_m, ign_rst));
        q1.push_back(model(1'b1, and_m, or_m, ign_rst));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (extra_starts) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_timeout", 64'(seen), 64'd1);
        if (extra_starts) begin
            start = 1'b1;
            @(negedge clk); start = 1'b0;
            chk("no_restart0", 64'({busy[0], done[0], pass[0], errc[0]}), 64'({1'b0, 1'b0, 1'b1, 4'd0}));
            chk("no_restart1", 64'({busy[1], done[1], pass[1], errc[1]}), 64'({1'b0, 1'b0, 1'b1, 4'd0}));
        end
        repeat (3) @(negedge clk);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        set_fault(8'hFF, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        set_fault(8'hFF, 8'h00, 1'b0); run(1'b0);
        set_fault(8'hFF, 8'h01, 1'b0); run(1'b0);
        set_fault(8'hFF, 8'h00, 1'b1); run(1'b0);
        set_fault(8'hFF, 8'h00, 1'b0); run(1'b1);

        // Reset asserted during the step-2 check cycle must abort without a done pulse.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        #1 check_zero("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run(1'b0);

        for (int n = 0; n < 16; n++) begin
            set_fault(($urandom_range(0, 1) == 1) ? ~(8'h01 << $urandom_range(0, 7)) : 8'hFF,
                      ($urandom_range(0, 1) == 1) ? (8'h01 << $urandom_range(0, 7)) : 8'h00,
                      1'($urandom_range(0, 3) == 0));
            run(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
